// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file arbiter between the
// DSP core and the host configuration port.
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RD_CAPTURE = 2'd1,
    RSP        = 2'd2
  } arb_state_t;

endpackage

// File: rtl/regfile_arbiter.sv
// Muxes the core and host onto the 2R/1W register file.
// The core has priority; a waiting host preempts after MAX_WAIT cycles.
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int REGADDR_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_WAIT      = 15
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     core_active,
  input  logic [REGADDR_WIDTH-1:0] core_readAddrA,
  input  logic [REGADDR_WIDTH-1:0] core_readAddrB,
  input  logic [REGADDR_WIDTH-1:0] core_writeAddr,
  input  logic [DATA_WIDTH-1:0]    core_dataW,
  input  logic                     core_writeEnable,
  output logic                     core_stall,
  output logic [DATA_WIDTH-1:0]    core_dataA,
  output logic [DATA_WIDTH-1:0]    core_dataB,
  output logic [REGADDR_WIDTH-1:0] rf_readAddrA,
  output logic [REGADDR_WIDTH-1:0] rf_readAddrB,
  output logic [REGADDR_WIDTH-1:0] rf_writeAddr,
  output logic [DATA_WIDTH-1:0]    rf_dataW,
  output logic                     rf_writeEnable,
  input  logic [DATA_WIDTH-1:0]    rf_dataA,
  input  logic [DATA_WIDTH-1:0]    rf_dataB,
  input  logic                     host_req_valid,
  output logic                     host_req_ready,
  input  logic                     host_req_write,
  input  logic [REGADDR_WIDTH-1:0] host_req_addr,
  input  logic [DATA_WIDTH-1:0]    host_req_data,
  output logic                     host_rsp_valid,
  input  logic                     host_rsp_ready,
  output logic [DATA_WIDTH-1:0]    host_rsp_data
);

  localparam int WAIT_WIDTH =
    (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_WIDTH-1:0] WAIT_MAX =
    WAIT_WIDTH'(MAX_WAIT);

  arb_state_t              r_state;
  arb_state_t              w_state_nxt;
  logic [WAIT_WIDTH-1:0]   r_wait_cnt;
  logic [WAIT_WIDTH-1:0]   w_wait_nxt;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic [DATA_WIDTH-1:0]   w_rsp_nxt;
  logic                    w_grant;

  assign core_dataA     = rf_dataA;
  assign core_dataB     = rf_dataB;
  assign host_rsp_valid = (r_state == RSP);
  assign host_rsp_data  = r_rsp_data;

  // Reset gating keeps the file untouched while reset is held
  always_comb begin
    w_grant = reset_n && (r_state == IDLE) && host_req_valid &&
              (!core_active || (r_wait_cnt == WAIT_MAX));

    rf_readAddrA   = core_readAddrA;
    rf_readAddrB   = core_readAddrB;
    rf_writeAddr   = core_writeAddr;
    rf_dataW       = core_dataW;
    rf_writeEnable = core_writeEnable && reset_n;
    host_req_ready = w_grant;
    core_stall     = w_grant && core_active;
    w_state_nxt    = r_state;
    w_rsp_nxt      = r_rsp_data;
    w_wait_nxt     = r_wait_cnt;

    unique case (r_state)
      IDLE: begin
        if (w_grant) begin
          if (host_req_write) begin
            rf_writeAddr   = host_req_addr;
            rf_dataW       = host_req_data;
            rf_writeEnable = 1'b1;
            w_rsp_nxt      = '0;
            w_state_nxt    = RSP;
          end else begin
            rf_readAddrA   = host_req_addr;
            rf_writeEnable = 1'b0;
            w_state_nxt    = RD_CAPTURE;
          end
        end
      end
      RD_CAPTURE: begin
        w_rsp_nxt   = rf_dataA;
        w_state_nxt = RSP;
      end
      RSP: begin
        if (host_rsp_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (!host_req_valid || w_grant) begin
      w_wait_nxt = '0;
    end else if ((r_state == IDLE) && core_active &&
                 (r_wait_cnt != WAIT_MAX)) begin
      w_wait_nxt = r_wait_cnt + WAIT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_rsp_data <= w_rsp_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural
// register file (posedge read, negedge write, r0 reads zero).
module tb_regfile_arbiter;

  logic        clk;
  logic        reset_n;
  logic        core_active;
  logic [4:0]  core_readAddrA;
  logic [4:0]  core_readAddrB;
  logic [4:0]  core_writeAddr;
  logic [31:0] core_dataW;
  logic        core_writeEnable;
  logic        core_stall;
  logic [31:0] core_dataA;
  logic [31:0] core_dataB;
  logic [4:0]  rf_readAddrA;
  logic [4:0]  rf_readAddrB;
  logic [4:0]  rf_writeAddr;
  logic [31:0] rf_dataW;
  logic        rf_writeEnable;
  logic [31:0] rf_dataA;
  logic [31:0] rf_dataB;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_req_write;
  logic [4:0]  host_req_addr;
  logic [31:0] host_req_data;
  logic        host_rsp_valid;
  logic        host_rsp_ready;
  logic [31:0] host_rsp_data;

  logic        z_stall;
  logic [31:0] z_dataA;
  logic [31:0] z_dataB;
  logic [4:0]  z_raA;
  logic [4:0]  z_raB;
  logic [4:0]  z_wa;
  logic [31:0] z_dW;
  logic        z_we;
  logic        z_ready;
  logic        z_rv;
  logic [31:0] z_rd;

  int n_tot;
  int n_pass;

  regfile_arbiter #(
    .REGADDR_WIDTH(5), .DATA_WIDTH(32), .MAX_WAIT(15)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .core_active(core_active),
    .core_readAddrA(core_readAddrA),
    .core_readAddrB(core_readAddrB),
    .core_writeAddr(core_writeAddr),
    .core_dataW(core_dataW),
    .core_writeEnable(core_writeEnable),
    .core_stall(core_stall),
    .core_dataA(core_dataA), .core_dataB(core_dataB),
    .rf_readAddrA(rf_readAddrA), .rf_readAddrB(rf_readAddrB),
    .rf_writeAddr(rf_writeAddr), .rf_dataW(rf_dataW),
    .rf_writeEnable(rf_writeEnable),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
    .host_req_valid(host_req_valid),
    .host_req_ready(host_req_ready),
    .host_req_write(host_req_write),
    .host_req_addr(host_req_addr),
    .host_req_data(host_req_data),
    .host_rsp_valid(host_rsp_valid),
    .host_rsp_ready(host_rsp_ready),
    .host_rsp_data(host_rsp_data)
  );

  // Immediate-preemption variant sharing the same stimulus
  regfile_arbiter #(
    .REGADDR_WIDTH(5), .DATA_WIDTH(32), .MAX_WAIT(0)
  ) dut0 (
    .clk(clk), .reset_n(reset_n),
    .core_active(core_active),
    .core_readAddrA(core_readAddrA),
    .core_readAddrB(core_readAddrB),
    .core_writeAddr(core_writeAddr),
    .core_dataW(core_dataW),
    .core_writeEnable(core_writeEnable),
    .core_stall(z_stall),
    .core_dataA(z_dataA), .core_dataB(z_dataB),
    .rf_readAddrA(z_raA), .rf_readAddrB(z_raB),
    .rf_writeAddr(z_wa), .rf_dataW(z_dW),
    .rf_writeEnable(z_we),
    .rf_dataA(rf_dataA), .rf_dataB(rf_dataB),
    .host_req_valid(host_req_valid),
    .host_req_ready(z_ready),
    .host_req_write(host_req_write),
    .host_req_addr(host_req_addr),
    .host_req_data(host_req_data),
    .host_rsp_valid(z_rv),
    .host_rsp_ready(host_rsp_ready),
    .host_rsp_data(z_rd)
  );

  logic [31:0] mem [32];

  always @(negedge clk)
    if (rf_writeEnable) mem[rf_writeAddr] <= rf_dataW;

  always @(posedge clk) begin
    rf_dataA <= (rf_readAddrA == 5'd0) ? 32'd0 : mem[rf_readAddrA];
    rf_dataB <= (rf_readAddrB == 5'd0) ? 32'd0 : mem[rf_readAddrB];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ca;
    logic        cwe;
    logic        hv;
    logic        hw;
    logic [4:0]  ha;
    logic [31:0] hd;
    logic        rr;
    logic        x_rdy;
    logic        x_stall;
    logic        x_we;
    logic [4:0]  x_wa;
    logic [4:0]  x_ra;
    logic        x_rv;
    logic [31:0] x_rd;
  } vec_t;

  vec_t vt [11];

  function automatic vec_t mk(
    logic ca, logic cwe, logic hv, logic hw,
    logic [4:0] ha, logic [31:0] hd, logic rr,
    logic x_rdy, logic x_stall, logic x_we,
    logic [4:0] x_wa, logic [4:0] x_ra,
    logic x_rv, logic [31:0] x_rd);
    vec_t v;
    v.ca = ca; v.cwe = cwe; v.hv = hv; v.hw = hw;
    v.ha = ha; v.hd = hd; v.rr = rr;
    v.x_rdy = x_rdy; v.x_stall = x_stall; v.x_we = x_we;
    v.x_wa = x_wa; v.x_ra = x_ra;
    v.x_rv = x_rv; v.x_rd = x_rd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [4:0] a,
                         input logic [31:0] exp,
                         input string nm);
    host_req_valid = 1'b1;
    host_req_write = 1'b0;
    host_req_addr  = a;
    host_rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(host_req_ready), 32'd1);
    next_cyc();
    host_req_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early_valid"}, 32'(host_rsp_valid), 32'd0);
    next_cyc();
    host_rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(host_rsp_valid), 32'd1);
    chk({nm, "_data"}, host_rsp_data, exp);
    next_cyc();
    host_rsp_ready = 1'b0;
  endtask

  // Waits with the core active until the host is granted.
  task automatic wait_grant(input string nm, output int k);
    int stalls;
    stalls = 0;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (host_req_ready) begin
        k = i;
        break;
      end
      if (core_stall) stalls++;
      next_cyc();
    end
    chk({nm, "_stall_before_grant"}, 32'(stalls), 32'd0);
    if (k == 0) begin
      n_tot++;
      $display("FAIL %s_timeout: no grant within 40 cycles", nm);
    end
  endtask

  initial begin
    int k;
    n_tot  = 0;
    n_pass = 0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;

    reset_n          = 1'b0;
    core_active      = 1'b0;
    core_readAddrA   = 5'd9;
    core_readAddrB   = 5'd10;
    core_writeAddr   = 5'd12;
    core_dataW       = 32'h0BADF00D;
    core_writeEnable = 1'b0;
    host_req_valid   = 1'b0;
    host_req_write   = 1'b0;
    host_req_addr    = 5'd0;
    host_req_data    = 32'd0;
    host_rsp_ready   = 1'b0;

    vt[0]  = mk(0,0,1,1,5'd7,32'hDEADBEEF,1, 1,0,1,5'd7,5'd9,0,32'd0);
    vt[1]  = mk(0,0,0,0,5'd0,32'd0,1,        0,0,0,5'd12,5'd9,1,32'd0);
    vt[2]  = mk(0,1,1,0,5'd7,32'd0,1,        1,0,0,5'd12,5'd7,0,32'd0);
    vt[3]  = mk(0,0,0,0,5'd0,32'd0,0,        0,0,0,5'd12,5'd9,0,32'd0);
    vt[4]  = mk(0,0,0,0,5'd0,32'd0,1,        0,0,0,5'd12,5'd9,1,32'hDEADBEEF);
    vt[5]  = mk(0,0,1,1,5'd0,32'hFFFFFFFF,1, 1,0,1,5'd0,5'd9,0,32'd0);
    vt[6]  = mk(0,0,0,0,5'd0,32'd0,1,        0,0,0,5'd12,5'd9,1,32'd0);
    vt[7]  = mk(0,0,1,0,5'd0,32'd0,1,        1,0,0,5'd12,5'd0,0,32'd0);
    vt[8]  = mk(0,0,0,0,5'd0,32'd0,1,        0,0,0,5'd12,5'd9,0,32'd0);
    vt[9]  = mk(0,0,0,0,5'd0,32'd0,1,        0,0,0,5'd12,5'd9,1,32'd0);
    vt[10] = mk(1,1,0,0,5'd0,32'd0,0,        0,0,1,5'd12,5'd9,0,32'd0);

    #2;
    core_writeEnable = 1'b1;
    #1;
    chk("rst_ready", 32'(host_req_ready), 32'd0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_rf_we", 32'(rf_writeEnable), 32'd0);
    chk("rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
    chk("rst_rsp_data", host_rsp_data, 32'd0);
    core_writeEnable = 1'b0;
    next_cyc();
    next_cyc();
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      core_active      = vt[i].ca;
      core_writeEnable = vt[i].cwe;
      host_req_valid   = vt[i].hv;
      host_req_write   = vt[i].hw;
      host_req_addr    = vt[i].ha;
      host_req_data    = vt[i].hd;
      host_rsp_ready   = vt[i].rr;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), 32'(host_req_ready),
          32'(vt[i].x_rdy));
      chk($sformatf("v%0d_stall", i), 32'(core_stall),
          32'(vt[i].x_stall));
      chk($sformatf("v%0d_rf_we", i), 32'(rf_writeEnable),
          32'(vt[i].x_we));
      chk($sformatf("v%0d_rf_wa", i), 32'(rf_writeAddr),
          32'(vt[i].x_wa));
      chk($sformatf("v%0d_rf_ra", i), 32'(rf_readAddrA),
          32'(vt[i].x_ra));
      chk($sformatf("v%0d_rsp_valid", i), 32'(host_rsp_valid),
          32'(vt[i].x_rv));
      if (vt[i].x_rv)
        chk($sformatf("v%0d_rsp_data", i), host_rsp_data,
            vt[i].x_rd);
      next_cyc();
    end

    core_active      = 1'b1;
    core_writeEnable = 1'b0;
    host_req_valid   = 1'b1;
    host_req_write   = 1'b0;
    host_req_addr    = 5'd7;
    host_rsp_ready   = 1'b0;
    @(negedge clk);
    chk("busy_no_grant", 32'(host_req_ready), 32'd0);
    chk("busy_no_stall", 32'(core_stall), 32'd0);
    chk("mw0_grant", 32'(z_ready), 32'd1);
    chk("mw0_stall", 32'(z_stall), 32'd1);
    next_cyc();

    // Preload r3, then a read that must wait out MAX_WAIT
    core_active    = 1'b0;
    host_req_valid = 1'b1;
    host_req_write = 1'b1;
    host_req_addr  = 5'd3;
    host_req_data  = 32'h12345678;
    host_rsp_ready = 1'b1;
    next_cyc();
    host_req_valid = 1'b0;
    next_cyc();

    core_active    = 1'b1;
    host_req_valid = 1'b1;
    host_req_write = 1'b0;
    host_req_addr  = 5'd3;
    host_rsp_ready = 1'b0;
    wait_grant("wait", k);
    chk("wait_grant_cycle", 32'(k), 32'd16);
    chk("wait_grant_stall", 32'(core_stall), 32'd1);
    chk("wait_rf_ra", 32'(rf_readAddrA), 32'd3);
    next_cyc();
    host_req_valid = 1'b0;
    @(negedge clk);
    chk("wait_stall_after", 32'(core_stall), 32'd0);
    chk("wait_rsp_early", 32'(host_rsp_valid), 32'd0);
    next_cyc();
    host_rsp_ready = 1'b1;
    @(negedge clk);
    chk("wait_rsp_valid", 32'(host_rsp_valid), 32'd1);
    chk("wait_rsp_data", host_rsp_data, 32'h12345678);
    next_cyc();

    // Host write to r5 preempting a core write to r5
    core_active      = 1'b1;
    core_writeEnable = 1'b1;
    core_writeAddr   = 5'd5;
    core_dataW       = 32'hAAAAAAAA;
    host_req_valid   = 1'b1;
    host_req_write   = 1'b1;
    host_req_addr    = 5'd5;
    host_req_data    = 32'h55555555;
    host_rsp_ready   = 1'b1;
    wait_grant("pre", k);
    chk("pre_grant_cycle", 32'(k), 32'd16);
    chk("pre_stall", 32'(core_stall), 32'd1);
    chk("pre_rf_we", 32'(rf_writeEnable), 32'd1);
    chk("pre_rf_wa", 32'(rf_writeAddr), 32'd5);
    chk("pre_rf_dw", rf_dataW, 32'h55555555);
    next_cyc();
    core_active      = 1'b0;
    core_writeEnable = 1'b0;
    core_writeAddr   = 5'd12;
    host_req_valid   = 1'b0;
    next_cyc();
    do_read(5'd5, 32'h55555555, "pre_rd");

    // Response held while the host is not ready
    host_req_valid = 1'b1;
    host_req_write = 1'b0;
    host_req_addr  = 5'd7;
    host_rsp_ready = 1'b0;
    next_cyc();
    host_req_write = 1'b1;
    host_req_addr  = 5'd9;
    host_req_data  = 32'h00C0FFEE;
    next_cyc();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", i), 32'(host_rsp_valid),
          32'd1);
      chk($sformatf("hold%0d_data", i), host_rsp_data,
          32'hDEADBEEF);
      chk($sformatf("hold%0d_ready", i), 32'(host_req_ready),
          32'd0);
      next_cyc();
    end
    host_rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_consume_ready", 32'(host_req_ready), 32'd0);
    next_cyc();
    host_rsp_ready = 1'b0;
    @(negedge clk);
    chk("hold_next_grant", 32'(host_req_ready), 32'd1);
    chk("hold_next_we", 32'(rf_writeEnable), 32'd1);
    next_cyc();
    host_req_valid = 1'b0;
    host_rsp_ready = 1'b1;
    next_cyc();
    host_rsp_ready = 1'b0;

    // Reset asserted while a read is in RD_CAPTURE
    host_req_valid = 1'b1;
    host_req_write = 1'b0;
    host_req_addr  = 5'd7;
    next_cyc();
    reset_n          = 1'b0;
    core_active      = 1'b1;
    core_writeEnable = 1'b1;
    #1;
    chk("mrst_rsp_valid", 32'(host_rsp_valid), 32'd0);
    chk("mrst_rf_we", 32'(rf_writeEnable), 32'd0);
    chk("mrst_ready", 32'(host_req_ready), 32'd0);
    chk("mrst_stall", 32'(core_stall), 32'd0);
    next_cyc();
    reset_n          = 1'b1;
    core_active      = 1'b0;
    core_writeEnable = 1'b0;
    host_req_valid   = 1'b0;
    @(negedge clk);
    chk("mrst_rsp_after", 32'(host_rsp_valid), 32'd0);
    next_cyc();
    do_read(5'd7, 32'hDEADBEEF, "mrst_rd");
    do_read(5'd9, 32'h00C0FFEE, "hold_wr_rd");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
